// File: rtl/cfg_shadow_pkg.sv
// cfg_shadow_pkg: shared types for the cfg shadow BRAM arbiter.
// FSM states, pending cfg request bundle and byte-merge helper.
package cfg_shadow_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG_RD,
    CFG_RMW_RD,
    CFG_RMW_WR,
    HOST_RD,
    RSP
  } state_t;

  localparam int REG_W  = 10;
  localparam int FUNC_W = 4;

  localparam logic [3:0] FULL_BE = 4'hF;

  typedef struct packed {
    logic              is_write;
    logic [REG_W-1:0]  addr;
    logic [FUNC_W-1:0] func;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } cfg_req_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cfg_shadow_starve_ctr.sv
// cfg_shadow_starve_ctr: counts host wait cycles, saturating at LIMIT.
// force_o requests host priority once the limit is reached.
module cfg_shadow_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  input  logic grant_i,
  output logic force_o
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: clear on grant, else step while waiting
  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_o = (cnt_q == LIM);

endmodule

// File: rtl/cfg_shadow_port_arbiter.sv
// cfg_shadow_port_arbiter: shares the shadow cfg BRAM between cfg_ext and host CSR.
// Define CFG_SHADOW_STATS_EN to add saturating activity counters.
module cfg_shadow_port_arbiter
  import cfg_shadow_pkg::*;
#(
  parameter int ADDR_W            = 10,
  parameter int FUNC_NUM          = 0,
  parameter int HOST_STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_ext_read_received,
  input  logic              cfg_ext_write_received,
  input  logic [9:0]        cfg_ext_register_number,
  input  logic [3:0]        cfg_ext_function_number,
  input  logic [31:0]       cfg_ext_write_data,
  input  logic [3:0]        cfg_ext_write_byte_enable,
  output logic [31:0]       cfg_ext_read_data,
  output logic              cfg_ext_read_data_valid,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_write,
  input  logic [11:0]       host_req_addr,
  input  logic [31:0]       host_req_wdata,
  output logic              host_rsp_valid,
  output logic [31:0]       host_rsp_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              cfg_overrun
`ifdef CFG_SHADOW_STATS_EN
  ,
  output logic [15:0]       stat_cfg_rd,
  output logic [15:0]       stat_cfg_wr,
  output logic [15:0]       stat_host_stall
`endif
);

  state_t            state_q, state_d;
  cfg_req_t          pend_q, pend_d;
  cfg_req_t          cur_q, cur_d;
  logic              pend_vld_q, pend_vld_d;
  logic              rsp_host_q, rsp_host_d;
  logic              rd_zero_q, rd_zero_d;
  logic              ovr_q, ovr_d;
  logic              cfg_vld_q, cfg_vld_d;
  logic [31:0]       cfg_data_q, cfg_data_d;
  logic              hrsp_vld_q, hrsp_vld_d;
  logic [31:0]       hrsp_data_q, hrsp_data_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              starve_force;
  logic              host_sel;
  logic              host_hs;
  logic              host_wait;
  logic              take;
  logic              func_ok;
  logic              pend_full;
  logic              pend_nz;
  logic              cfg_pulse;
  logic [ADDR_W-1:0] host_word;
  logic [ADDR_W-1:0] pend_word;
  logic [ADDR_W-1:0] cur_word;

  assign host_word = ADDR_W'(host_req_addr[11:2]);
  assign pend_word = ADDR_W'(pend_q.addr);
  assign cur_word  = ADDR_W'(cur_q.addr);

  assign func_ok   = (pend_q.func == FUNC_W'(FUNC_NUM));
  assign pend_full = (pend_q.be == FULL_BE);
  assign pend_nz   = |pend_q.be;
  assign cfg_pulse = cfg_ext_read_received | cfg_ext_write_received;

  // host wins IDLE only with no cfg pending or once starved
  assign host_sel  = host_req_valid & (~pend_vld_q | starve_force);
  assign host_req_ready = (state_q == IDLE) & host_sel;
  assign host_hs   = host_req_valid & host_req_ready;
  assign host_wait = host_req_valid & ~host_req_ready;
  assign take      = (state_q == IDLE) & pend_vld_q & ~host_sel;

  cfg_shadow_starve_ctr #(
    .LIMIT   (HOST_STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .wait_i  (host_wait),
    .grant_i (host_hs),
    .force_o (starve_force)
  );

  // pending slot: latest pulse wins, write beats simultaneous read
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovr_d      = ovr_q;
    if (take) pend_vld_d = 1'b0;
    if (cfg_pulse) begin
      pend_vld_d      = 1'b1;
      pend_d.is_write = cfg_ext_write_received;
      pend_d.addr     = cfg_ext_register_number;
      pend_d.func     = cfg_ext_function_number;
      pend_d.wdata    = cfg_ext_write_data;
      pend_d.be       = cfg_ext_write_byte_enable;
      if (pend_vld_q && !take) ovr_d = 1'b1;
    end
  end

  // FSM next state and registered BRAM / response outputs
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rsp_host_d  = rsp_host_q;
    rd_zero_d   = rd_zero_q;
    cfg_vld_d   = 1'b0;
    cfg_data_d  = cfg_data_q;
    hrsp_vld_d  = 1'b0;
    hrsp_data_d = hrsp_data_q;
    en_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (host_hs) begin
          en_d   = 1'b1;
          addr_d = host_word;
          if (host_req_write) begin
            we_d    = 1'b1;
            wdata_d = host_req_wdata;
          end else begin
            rsp_host_d = 1'b1;
            state_d    = HOST_RD;
          end
        end else if (take) begin
          cur_d = pend_q;
          if (!pend_q.is_write) begin
            rsp_host_d = 1'b0;
            rd_zero_d  = ~func_ok;
            state_d    = CFG_RD;
            if (func_ok) begin
              en_d   = 1'b1;
              addr_d = pend_word;
            end
          end else if (func_ok && pend_full) begin
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = pend_word;
            wdata_d = pend_q.wdata;
          end else if (func_ok && pend_nz) begin
            en_d    = 1'b1;
            addr_d  = pend_word;
            state_d = CFG_RMW_RD;
          end
        end
      end
      CFG_RD:     state_d = RSP;
      HOST_RD:    state_d = RSP;
      CFG_RMW_RD: state_d = CFG_RMW_WR;
      CFG_RMW_WR: begin
        en_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = cur_word;
        wdata_d = be_merge(bram_rdata, cur_q.wdata, cur_q.be);
        state_d = IDLE;
      end
      RSP: begin
        if (rsp_host_q) begin
          hrsp_vld_d  = 1'b1;
          hrsp_data_d = bram_rdata;
        end else begin
          cfg_vld_d  = 1'b1;
          cfg_data_d = rd_zero_q ? 32'h0 : bram_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset aborts any in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cur_q       <= '0;
      rsp_host_q  <= 1'b0;
      rd_zero_q   <= 1'b0;
      ovr_q       <= 1'b0;
      cfg_vld_q   <= 1'b0;
      cfg_data_q  <= '0;
      hrsp_vld_q  <= 1'b0;
      hrsp_data_q <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cur_q       <= cur_d;
      rsp_host_q  <= rsp_host_d;
      rd_zero_q   <= rd_zero_d;
      ovr_q       <= ovr_d;
      cfg_vld_q   <= cfg_vld_d;
      cfg_data_q  <= cfg_data_d;
      hrsp_vld_q  <= hrsp_vld_d;
      hrsp_data_q <= hrsp_data_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cfg_ext_read_data       = cfg_data_q;
  assign cfg_ext_read_data_valid = cfg_vld_q;
  assign host_rsp_valid          = hrsp_vld_q;
  assign host_rsp_rdata          = hrsp_data_q;
  assign bram_en                 = en_q;
  assign bram_we                 = we_q;
  assign bram_addr               = addr_q;
  assign bram_wdata              = wdata_q;
  assign cfg_overrun             = ovr_q;

  logic unused_bits;
  assign unused_bits = ^{host_req_addr[1:0], cur_q.is_write, cur_q.func};

`ifdef CFG_SHADOW_STATS_EN
  logic [15:0] st_rd_q, st_rd_d;
  logic [15:0] st_wr_q, st_wr_d;
  logic [15:0] st_stall_q, st_stall_d;
  logic        rd_done;
  logic        wr_done;

  // saturating counts of finished cfg ops and host wait cycles
  always_comb begin
    rd_done = (state_q == RSP) & ~rsp_host_q;
    wr_done = (state_q == CFG_RMW_WR) |
              (take & pend_q.is_write & pend_nz &
               (pend_full | ~func_ok));
    st_rd_d    = st_rd_q;
    st_wr_d    = st_wr_q;
    st_stall_d = st_stall_q;
    if (rd_done && st_rd_q != 16'hFFFF)      st_rd_d    = st_rd_q + 16'd1;
    if (wr_done && st_wr_q != 16'hFFFF)      st_wr_d    = st_wr_q + 16'd1;
    if (host_wait && st_stall_q != 16'hFFFF) st_stall_d = st_stall_q + 16'd1;
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_rd_q    <= '0;
      st_wr_q    <= '0;
      st_stall_q <= '0;
    end else begin
      st_rd_q    <= st_rd_d;
      st_wr_q    <= st_wr_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_cfg_rd     = st_rd_q;
  assign stat_cfg_wr     = st_wr_q;
  assign stat_host_stall = st_stall_q;
`endif

endmodule

// File: tb/tb_cfg_shadow_port_arbiter.sv
// tb_cfg_shadow_port_arbiter: scoreboard bench with a behavioural BRAM.
// Expected responses are queued at issue and checked by monitors.
module tb_cfg_shadow_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_ext_read_received;
  logic        cfg_ext_write_received;
  logic [9:0]  cfg_ext_register_number;
  logic [3:0]  cfg_ext_function_number;
  logic [31:0] cfg_ext_write_data;
  logic [3:0]  cfg_ext_write_byte_enable;
  logic [31:0] cfg_ext_read_data;
  logic        cfg_ext_read_data_valid;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_write;
  logic [11:0] host_req_addr;
  logic [31:0] host_req_wdata;
  logic        host_rsp_valid;
  logic [31:0] host_rsp_rdata;
  logic        bram_en;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;
  logic        cfg_overrun;
`ifdef CFG_SHADOW_STATS_EN
  logic [15:0] stat_cfg_rd;
  logic [15:0] stat_cfg_wr;
  logic [15:0] stat_host_stall;
`endif

  cfg_shadow_port_arbiter dut (
    .clk                       (clk),
    .reset                     (reset),
    .cfg_ext_read_received     (cfg_ext_read_received),
    .cfg_ext_write_received    (cfg_ext_write_received),
    .cfg_ext_register_number   (cfg_ext_register_number),
    .cfg_ext_function_number   (cfg_ext_function_number),
    .cfg_ext_write_data        (cfg_ext_write_data),
    .cfg_ext_write_byte_enable (cfg_ext_write_byte_enable),
    .cfg_ext_read_data         (cfg_ext_read_data),
    .cfg_ext_read_data_valid   (cfg_ext_read_data_valid),
    .host_req_valid            (host_req_valid),
    .host_req_ready            (host_req_ready),
    .host_req_write            (host_req_write),
    .host_req_addr             (host_req_addr),
    .host_req_wdata            (host_req_wdata),
    .host_rsp_valid            (host_rsp_valid),
    .host_rsp_rdata            (host_rsp_rdata),
    .bram_en                   (bram_en),
    .bram_we                   (bram_we),
    .bram_addr                 (bram_addr),
    .bram_wdata                (bram_wdata),
    .bram_rdata                (bram_rdata),
    .cfg_overrun               (cfg_overrun)
`ifdef CFG_SHADOW_STATS_EN
    ,
    .stat_cfg_rd               (stat_cfg_rd),
    .stat_cfg_wr               (stat_cfg_wr),
    .stat_host_stall           (stat_host_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural single-port BRAM, 1-cycle read latency
  logic [31:0] mem [0:1023];
  int acc_cnt = 0;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    bram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (bram_en) begin
      acc_cnt <= acc_cnt + 1;
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr];
    end
  end

  typedef struct {
    logic [31:0] data;
    int          t;
    int          lmin;
    int          lmax;
  } exp_t;

  exp_t cfg_q[$];
  exp_t host_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [111:0] outs_vec;
  assign outs_vec = {cfg_ext_read_data, cfg_ext_read_data_valid,
                     host_req_ready, host_rsp_valid, host_rsp_rdata,
                     bram_en, bram_we, bram_addr, bram_wdata,
                     cfg_overrun};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // cfg read response monitor
  exp_t cm;
  int   clat;
  always @(negedge clk) begin
    if (cfg_ext_read_data_valid) begin
      checks++;
      if (cfg_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_unexpected_strobe data=%h cyc=%0d",
                 cfg_ext_read_data, cyc);
      end else begin
        cm   = cfg_q.pop_front();
        clat = cyc - cm.t;
        if (cfg_ext_read_data !== cm.data ||
            clat < cm.lmin || clat > cm.lmax) begin
          errors++;
          $display("FAIL cfg_rsp actual=%h lat=%0d required=%h lat=%0d..%0d",
                   cfg_ext_read_data, clat, cm.data, cm.lmin, cm.lmax);
        end
      end
    end
  end

  // host read response monitor
  exp_t hm;
  int   hlat;
  always @(negedge clk) begin
    if (host_rsp_valid) begin
      checks++;
      if (host_q.size() == 0) begin
        errors++;
        $display("FAIL host_unexpected_strobe data=%h cyc=%0d",
                 host_rsp_rdata, cyc);
      end else begin
        hm   = host_q.pop_front();
        hlat = cyc - hm.t;
        if (host_rsp_rdata !== hm.data ||
            hlat < hm.lmin || hlat > hm.lmax) begin
          errors++;
          $display("FAIL host_rsp actual=%h lat=%0d required=%h lat=%0d",
                   host_rsp_rdata, hlat, hm.data, hm.lmin);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  task automatic cfg_rd(input logic [9:0] r, input logic [3:0] f,
                        input logic [31:0] d, input int lmin,
                        input int lmax);
    cfg_ext_read_received   = 1'b1;
    cfg_ext_register_number = r;
    cfg_ext_function_number = f;
    cfg_q.push_back('{data: d, t: cyc + 1, lmin: lmin, lmax: lmax});
    tick();
    cfg_ext_read_received   = 1'b0;
  endtask

  task automatic cfg_wr(input logic [9:0] r, input logic [3:0] f,
                        input logic [31:0] d, input logic [3:0] b,
                        input bit also_rd);
    cfg_ext_write_received    = 1'b1;
    cfg_ext_read_received     = also_rd;
    cfg_ext_register_number   = r;
    cfg_ext_function_number   = f;
    cfg_ext_write_data        = d;
    cfg_ext_write_byte_enable = b;
    tick();
    cfg_ext_write_received    = 1'b0;
    cfg_ext_read_received     = 1'b0;
  endtask

  task automatic host_op(input bit wr, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] d,
                         output int waits);
    bit done;
    done           = 1'b0;
    waits          = 0;
    host_req_valid = 1'b1;
    host_req_write = wr;
    host_req_addr  = a;
    host_req_wdata = wd;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (host_req_ready) begin
        if (!wr) host_q.push_back('{data: d, t: cyc + 1, lmin: 2, lmax: 2});
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    host_req_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL host_handshake_timeout addr=%h", a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int w;
  int w4;
  int a0;

  initial begin
    reset                     = 1'b1;
    cfg_ext_read_received     = 1'b0;
    cfg_ext_write_received    = 1'b0;
    cfg_ext_register_number   = '0;
    cfg_ext_function_number   = '0;
    cfg_ext_write_data        = '0;
    cfg_ext_write_byte_enable = '0;
    host_req_valid            = 1'b0;
    host_req_write            = 1'b0;
    host_req_addr             = '0;
    host_req_wdata            = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", outs_vec, 0);
    tick();
    reset = 1'b0;
    drain();

    // host write then host read (addr low bits ignored)
    host_op(1'b1, 12'h004, 32'h12345678, 32'h0, w);
    host_op(1'b0, 12'h007, 32'h0, 32'h12345678, w);
    drain();

    // uncontended cfg read: strobe exactly 3 edges after pulse
    cfg_rd(10'd1, 4'd0, 32'h12345678, 3, 3);
    drain();

    // host held while cfg reads arrive every 3 cycles
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          cfg_rd(10'd1, 4'd0, 32'h12345678, 3, 6);
          tick();
          tick();
        end
      end
      begin
        tick();
        tick();
        tick();
        host_op(1'b0, 12'h004, 32'h0, 32'h12345678, w4);
      end
    join
    chk("host_starve_waits", w4, 4);
    drain();

    // partial write read-modify-write
    host_op(1'b1, 12'h004, 32'h87654321, 32'h0, w);
    drain();
    a0 = acc_cnt;
    cfg_wr(10'd1, 4'd0, 32'hAABBCCDD, 4'h5, 1'b0);
    drain();
    chk("rmw_access_count", acc_cnt - a0, 2);
    cfg_rd(10'd1, 4'd0, 32'h87BB43DD, 3, 3);
    drain();

    // foreign function and BE=0 never touch the BRAM
    cfg_rd(10'd1, 4'd1, 32'h0, 3, 3);
    drain();
    a0 = acc_cnt;
    cfg_wr(10'd1, 4'd1, 32'hFFFFFFFF, 4'hF, 1'b0);
    cfg_wr(10'd1, 4'd0, 32'hFFFFFFFF, 4'h0, 1'b0);
    drain();
    chk("dropped_write_access", acc_cnt - a0, 0);
    cfg_rd(10'd1, 4'd0, 32'h87BB43DD, 3, 3);
    drain();

    // read+write together: write kept, no read strobe
    cfg_wr(10'd2, 4'd0, 32'h00002222, 4'hF, 1'b1);
    drain();
    cfg_rd(10'd2, 4'd0, 32'h00002222, 3, 3);
    drain();
    chk("overrun_clear", cfg_overrun, 0);

    // third pulse lands while RMW holds the FSM and slot is full
    cfg_wr(10'd3, 4'd0, 32'h000000A1, 4'h1, 1'b0);
    cfg_wr(10'd4, 4'd0, 32'h00000044, 4'hF, 1'b0);
    cfg_wr(10'd4, 4'd0, 32'h00000055, 4'hF, 1'b0);
    drain();
    chk("overrun_set", cfg_overrun, 1);
    cfg_rd(10'd3, 4'd0, 32'h000000A1, 3, 3);
    drain();
    cfg_rd(10'd4, 4'd0, 32'h00000055, 3, 3);
    drain();

    // reset while in CFG_RMW_WR
    a0 = acc_cnt;
    cfg_wr(10'd1, 4'd0, 32'hFFFFFFFF, 4'h3, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rmw_reset_outs", outs_vec, 0);
    tick();
    reset = 1'b0;
    drain();
    chk("rmw_reset_word", mem[1], 32'h87BB43DD);
    chk("rmw_reset_access", acc_cnt - a0, 1);

    // reset while in CFG_RD: no strobe may follow
    cfg_ext_read_received   = 1'b1;
    cfg_ext_register_number = 10'd1;
    cfg_ext_function_number = 4'd0;
    tick();
    cfg_ext_read_received   = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    drain();

    cfg_rd(10'd1, 4'd0, 32'h87BB43DD, 3, 3);
    drain();
`ifdef CFG_SHADOW_STATS_EN
    chk("stat_cfg_rd", stat_cfg_rd, 1);
    chk("stat_cfg_wr", stat_cfg_wr, 0);
    chk("stat_host_stall", stat_host_stall, 0);
`endif

    chk("cfg_sb_leftover", cfg_q.size(), 0);
    chk("host_sb_leftover", host_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
